inst_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the single-cycle MIPS core.
- Takes the core's `pc`, fetches the word from a variable-latency instruction memory over a req/ack handshake, and presents `inst` to the core.
- Stalls the core with `core_stall` until the fetched word is valid, so the core commits exactly one instruction per completed fetch.
- Also flags misaligned-PC and memory-timeout faults.

---
 rtl/inst_fetch_unit_if.sv | 15 +
 rtl/inst_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: instruction-memory request/acknowledge bus.
//   imem_req   : fetch request (master -> memory)
//   imem_addr  : word-aligned fetch address (master -> memory)
//   imem_ack   : memory returns imem_rdata this cycle (memory -> master)
//   imem_rdata : fetched word (memory -> master)
// Modports: master (fetch unit), slave (memory model / memory controller).
interface inst_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch stage in front of a single-cycle MIPS core.
// Fetches the word at pc over a variable-latency req/ack memory bus and
// releases the core (core_stall=0, inst_valid=1) for exactly one cycle per
// completed fetch. Misaligned pc and memory timeouts substitute NOP_INST and
// raise sticky error flags; fetching continues after a fault.
// Ports:
//   CLK, reset       : clock, asynchronous active-high reset
//   pc               : core program counter (stable while core_stall=1)
//   inst, inst_valid : instruction word and its one-cycle issue strobe
//   core_stall       : ~inst_valid, core clock-enable gate
//   imem             : instruction-memory bus (master modport)
//   misalign_err     : sticky, a fetch was attempted with pc[1:0]!=0
//   timeout_err      : sticky, a fetch ran TIMEOUT cycles without ack
//   fetch_count      : number of issued instructions, wraps
// Optional build macro FETCH_LAST_HIT_EN: one-entry last-fetch register that
// serves a repeated pc without a memory request.
module inst_fetch_unit #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [31:0]          pc,
  output logic [31:0]          inst,
  output logic                 inst_valid,
  output logic                 core_stall,
  inst_fetch_unit_if.master    imem,
  output logic                 misalign_err,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        inst_q, inst_d;
  logic [15:0]        tcnt_q, tcnt_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
  logic               misalign_err_q, misalign_err_d;
  logic               timeout_err_q, timeout_err_d;
  logic               aligned, hit, req;

`ifdef FETCH_LAST_HIT_EN
  logic [31:0] last_addr_q, last_addr_d;
  logic [31:0] last_inst_q, last_inst_d;
  logic        last_valid_q, last_valid_d;
  // last_addr is always word aligned, so a misaligned pc can never hit.
  assign hit = last_valid_q && (pc == last_addr_q);
`else
  assign hit = 1'b0;
`endif

  assign aligned = (pc[1:0] == 2'b00);
  assign req     = (state_q == FETCH) && aligned && !hit;

  always_comb begin
    state_d        = state_q;
    inst_d         = inst_q;
    tcnt_d         = tcnt_q;
    fetch_count_d  = fetch_count_q;
    misalign_err_d = misalign_err_q;
    timeout_err_d  = timeout_err_q;
`ifdef FETCH_LAST_HIT_EN
    last_addr_d    = last_addr_q;
    last_inst_d    = last_inst_q;
    last_valid_d   = last_valid_q;
`endif
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (hit) begin
`ifdef FETCH_LAST_HIT_EN
          inst_d  = last_inst_q;
`endif
          tcnt_d  = '0;
          state_d = ISSUE;
        end else if (!aligned) begin
          inst_d         = NOP_INST;
          misalign_err_d = 1'b1;
          tcnt_d         = '0;
          state_d        = ISSUE;
        end else if (imem.imem_ack) begin
          inst_d  = imem.imem_rdata;
          tcnt_d  = '0;
          state_d = ISSUE;
`ifdef FETCH_LAST_HIT_EN
          last_addr_d  = {pc[31:2], 2'b00};
          last_inst_d  = imem.imem_rdata;
          last_valid_d = 1'b1;
`endif
        end else if (tcnt_q == 16'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th request cycle without ack: abort at the
          // edge so imem_req is high for exactly TIMEOUT cycles.
          inst_d        = NOP_INST;
          timeout_err_d = 1'b1;
          tcnt_d        = '0;
          state_d       = ISSUE;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      ISSUE: begin
        fetch_count_d = fetch_count_q + 1'b1;
        state_d       = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      inst_q         <= NOP_INST;
      tcnt_q         <= '0;
      fetch_count_q  <= '0;
      misalign_err_q <= 1'b0;
      timeout_err_q  <= 1'b0;
`ifdef FETCH_LAST_HIT_EN
      last_addr_q    <= '0;
      last_inst_q    <= '0;
      last_valid_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      inst_q         <= inst_d;
      tcnt_q         <= tcnt_d;
      fetch_count_q  <= fetch_count_d;
      misalign_err_q <= misalign_err_d;
      timeout_err_q  <= timeout_err_d;
`ifdef FETCH_LAST_HIT_EN
      last_addr_q    <= last_addr_d;
      last_inst_q    <= last_inst_d;
      last_valid_q   <= last_valid_d;
`endif
    end
  end

  // Gate with reset so an outstanding request is withdrawn immediately.
  assign imem.imem_req  = req && !reset;
  assign imem.imem_addr = {pc[31:2], 2'b00};

  assign inst         = inst_q;
  assign inst_valid   = (state_q == ISSUE);
  assign core_stall   = (state_q != ISSUE);
  assign misalign_err = misalign_err_q;
  assign timeout_err  = timeout_err_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: randomized fetch sequences against a per-instruction
// reference model (expected word, issue latency, request-cycle count, error
// flags, issue count), plus directed zero-wait, wait-state, misalign,
// timeout and reset-mid-fetch cases.
module tb_inst_fetch_unit;
  localparam int unsigned TO  = 4;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid, core_stall, misalign_err, timeout_err;
  logic [31:0] fetch_count;

  inst_fetch_unit_if ifc ();

  inst_fetch_unit #(.TIMEOUT(TO), .NOP_INST(NOP), .CNT_W(32)) dut (
    .CLK(CLK), .reset(reset), .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .core_stall(core_stall), .imem(ifc), .misalign_err(misalign_err),
    .timeout_err(timeout_err), .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [31:0] m_count;
  bit          m_mis, m_to;
  bit          m_last_valid;
  logic [31:0] m_last_addr, m_last_inst;
  logic [31:0] prev_inst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_count      = 0;
    m_mis        = 0;
    m_to         = 0;
    m_last_valid = 0;
    m_last_addr  = 0;
    m_last_inst  = 0;
    prev_inst    = NOP;
  endtask

  // One complete instruction: drive pc, act as memory with w wait states
  // (w >= TO means the memory never answers), and check the issue.
  task automatic run_inst(input logic [31:0] p, input logic [31:0] data,
                          input int w, input bit after_reset);
    bit          mis, hit, tmo;
    logic [31:0] e_inst;
    int          e_lat, e_req, reqc;
    pc  = p;
    mis = (p[1:0] != 2'b00);
`ifdef FETCH_LAST_HIT_EN
    hit = m_last_valid && (p == m_last_addr);
`else
    hit = 0;
`endif
    tmo = !mis && !hit && (w >= int'(TO));
    if (hit)      begin e_inst = m_last_inst; e_req = 0;     e_lat = 2; end
    else if (mis) begin e_inst = NOP;         e_req = 0;     e_lat = 2; end
    else if (tmo) begin e_inst = NOP;         e_req = TO;    e_lat = TO + 1; end
    else          begin e_inst = data;        e_req = w + 1; e_lat = w + 2; end
    if (after_reset) e_lat++;
    reqc = 0;
    for (int cyc = 1; cyc <= e_lat; cyc++) begin
      @(negedge CLK);
      if (ifc.imem_req) begin
        reqc++;
        chk("addr", ifc.imem_addr, {p[31:2], 2'b00});
        ifc.imem_ack   = (reqc == w + 1);
        ifc.imem_rdata = (reqc == w + 1) ? data : $urandom;
      end else begin
        // ack without request must be ignored, including a late ack
        ifc.imem_ack   = tmo ? 1'b1 : 1'($urandom_range(0, 1));
        ifc.imem_rdata = $urandom;
      end
      chk("valid", 32'(inst_valid), 32'(cyc == e_lat));
      chk("stall", 32'(core_stall), 32'(cyc != e_lat));
      if (cyc != e_lat) chk("hold", inst, prev_inst);
    end
    if (mis) m_mis = 1;
    if (tmo) m_to  = 1;
    if (!mis && !hit && !tmo) begin
      m_last_valid = 1; m_last_addr = p; m_last_inst = data;
    end
    chk("inst", inst, e_inst);
    chk("reqc", 32'(reqc), 32'(e_req));
    chk("count", fetch_count, m_count);
    chk("mis", 32'(misalign_err), 32'(m_mis));
    chk("tmo", 32'(timeout_err), 32'(m_to));
    m_count   = m_count + 1;
    prev_inst = e_inst;
  endtask

  task automatic rand_inst();
    logic [31:0] r, p;
    int          k, w;
    k = $urandom_range(0, 5);
    r = $urandom;
    case (k)
      0: p = 32'h0000_0000;
      1: p = 32'h0000_0004;
      2: p = 32'h0000_0010;
      3: p = 32'h0000_0040;
      4: p = {r[31:2], 2'b00};
      default: p = {r[31:2], 2'b00} | 32'(int'($urandom_range(1, 3)));
    endcase
    k = $urandom_range(0, 7);
    w = (k == 7) ? 6 : (k % 4);
    run_inst(p, $urandom, w, 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_inst"},  inst, NOP);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_stall"}, 32'(core_stall), 32'd1);
    chk({tag, "_req"},   32'(ifc.imem_req), 32'd0);
    chk({tag, "_cnt"},   fetch_count, 32'd0);
    chk({tag, "_mis"},   32'(misalign_err), 32'd0);
    chk({tag, "_tmo"},   32'(timeout_err), 32'd0);
  endtask

  initial begin
    int reqc;
    reset          = 1'b1;
    pc             = 32'h0;
    ifc.imem_ack   = 1'b0;
    ifc.imem_rdata = 32'h0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_reset_state("rst");
    @(posedge CLK); #1 reset = 1'b0;

    // directed: zero-wait, wait states, misalign, timeout
    run_inst(32'h0000_0000, 32'h2008_0005, 0, 1);
    run_inst(32'h0000_0000, 32'h2008_0005, 0, 0);
    run_inst(32'h0000_0004, 32'h8C09_0000, 3, 0);
    run_inst(32'h0000_0006, 32'hDEAD_BEEF, 0, 0);
    run_inst(32'h0000_0008, 32'h1111_2222, 0, 0);
    run_inst(32'h0000_0020, 32'h3333_4444, 9, 0);
    run_inst(32'h0000_0024, 32'h5555_6666, 1, 0);
    // branch-to-self
    run_inst(32'h0000_0010, 32'h1000_FFFF, 0, 0);
    repeat (3) run_inst(32'h0000_0010, $urandom, 0, 0);

    repeat (200) rand_inst();

    // reset during the second wait-state cycle of a fetch
    pc   = m_last_addr ^ 32'h0000_0100;
    reqc = 0;
    for (int i = 0; i < 10 && reqc < 2; i++) begin
      @(negedge CLK);
      ifc.imem_ack = 1'b0;
      if (ifc.imem_req) reqc++;
    end
    chk("midreq", 32'(reqc), 32'd2);
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_state("mid");
    @(posedge CLK); #1 reset = 1'b0;
    run_inst(pc, 32'hCAFE_0001, 2, 1);

    repeat (40) rand_inst();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
